// File: rtl/phold_pkg.sv
// Shared types and widths for the PHOLD logical-process core.
package phold_pkg;

  localparam int TIME_W = 16;  // event timestamp width
  localparam int LP_W   = 3;   // logical-process id width
  localparam int RND_W  = 8;   // shared PRNG width
  localparam int GVT_W  = 14;  // global virtual time width
  localparam int CNT_W  = 2;   // processing-delay counter width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PROC = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  // Timestamp for the generated event: base + random offset + increment,
  // clamped to the largest representable time instead of wrapping.
  function automatic logic [TIME_W-1:0] sat_time(input logic [TIME_W-1:0] base,
                                                 input logic [RND_W-1:0]  rnd,
                                                 input logic [TIME_W-1:0] inc);
    logic [TIME_W+1:0] sum;
    sum = {2'b00, base} + {{(TIME_W + 2 - RND_W){1'b0}}, rnd} + {2'b00, inc};
    return (sum[TIME_W+1:TIME_W] != 2'b00) ? {TIME_W{1'b1}} : sum[TIME_W-1:0];
  endfunction

endpackage

// File: rtl/lp_proc_if.sv
// Dispatcher <-> logical-process event bus. The core is the slave side.
interface lp_proc_if;
  import phold_pkg::*;

  logic              event_valid;
  logic [LP_W-1:0]   event_id;
  logic [TIME_W-1:0] event_time;
  logic [GVT_W-1:0]  global_time;
  logic [RND_W-1:0]  random_in;
  logic [TIME_W-1:0] new_event_time;
  logic [LP_W-1:0]   new_event_target;
  logic              new_event_ready;
  logic              ack;
  logic              ready;

  modport slave (
    input  event_valid, event_id, event_time, global_time, random_in, ack,
    output new_event_time, new_event_target, new_event_ready, ready
  );

  modport master (
    output event_valid, event_id, event_time, global_time, random_in, ack,
    input  new_event_time, new_event_target, new_event_ready, ready
  );
endinterface

// File: rtl/lp_delay_cnt.sv
// 2-bit processing-delay counter: load, decrement toward zero, zero flag.
module lp_delay_cnt
  import phold_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: load has priority, decrement stops at zero.
  always_comb begin
    // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments for state so every flop samples pre-edge values.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lp_proc.sv
// PHOLD logical-process core: accept an event, wait a random 1..4 cycles,
// then offer one generated event until the dispatcher acknowledges it.
// Build option: define LP_LOOKAHEAD_EN to use LOOKAHEAD as the minimum
// timestamp increment; otherwise the increment is 1.
module lp_proc
  import phold_pkg::*;
#(
  parameter int LOOKAHEAD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  lp_proc_if.slave   bus
);

  if (LOOKAHEAD < 1 || LOOKAHEAD > 65535) begin : g_bad_lookahead
    $error("lp_proc: LOOKAHEAD must be in 1..65535");
  end

`ifdef LP_LOOKAHEAD_EN
  localparam logic [TIME_W-1:0] INC = TIME_W'(LOOKAHEAD);
`else
  localparam logic [TIME_W-1:0] INC = 16'd1;
`endif

  state_e            state_q, state_d;
  logic [LP_W-1:0]   ev_id_q, ev_id_d;
  logic [TIME_W-1:0] ev_time_q, ev_time_d;
  logic [TIME_W-1:0] new_time_q, new_time_d;
  logic [LP_W-1:0]   new_tgt_q, new_tgt_d;
  logic              accept, cnt_zero, proc_done;

  assign accept    = (state_q == ST_IDLE) && bus.event_valid;
  assign proc_done = (state_q == ST_PROC) && cnt_zero;

  lp_delay_cnt u_delay_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept),
    .load_val_i (bus.random_in[CNT_W-1:0]),
    .dec_i      (state_q == ST_PROC),
    .zero_o     (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; event_valid only matters in IDLE, ack only in SEND.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.event_valid) state_d = ST_PROC;
      ST_PROC: if (cnt_zero)        state_d = ST_SEND;
      ST_SEND: if (bus.ack)         state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    bus.ready           = 1'b0;
    bus.new_event_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: bus.ready           = 1'b1;
      ST_SEND: bus.new_event_ready = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: latch on accept, compute the new event on PROC exit.
  always_comb begin
    ev_id_d    = ev_id_q;
    ev_time_d  = ev_time_q;
    new_time_d = new_time_q;
    new_tgt_d  = new_tgt_q;
    if (accept) begin
      ev_id_d   = bus.event_id;
      ev_time_d = bus.event_time;
    end
    if (proc_done) begin
      new_time_d = sat_time(ev_time_q, bus.random_in, INC);
      new_tgt_d  = bus.random_in[RND_W-1 -: LP_W] ^ ev_id_q;
    end
  end

  // Datapath registers; cleared on reset so the outputs read 0 afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_id_q    <= '0;
      ev_time_q  <= '0;
      new_time_q <= '0;
      new_tgt_q  <= '0;
    end else begin
      ev_id_q    <= ev_id_d;
      ev_time_q  <= ev_time_d;
      new_time_q <= new_time_d;
      new_tgt_q  <= new_tgt_d;
    end
  end

  assign bus.new_event_time   = new_time_q;
  assign bus.new_event_target = new_tgt_q;

endmodule

// File: tb/tb_lp_proc.sv
// Self-checking bench for lp_proc: directed table, hand-written corner
// sequences and randomized transactions against a behavioural model.
module tb_lp_proc;
  import phold_pkg::*;

  localparam int LA = 8;
`ifdef LP_LOOKAHEAD_EN
  localparam int TB_INC = LA;
`else
  localparam int TB_INC = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  lp_proc_if bus ();

  lp_proc #(.LOOKAHEAD(LA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Behavioural model of the generated event.
  function automatic int ref_time(input int t, input int r);
    int s;
    s = t + r + TB_INC;
    return (s > 65535) ? 65535 : s;
  endfunction

  function automatic int ref_tgt(input int id, input int r);
    return ((r / 32) % 8) ^ id;
  endfunction

  // One full transaction; called and returning at a falling edge.
  task automatic run_txn(input string tag, input int id, input int tm, input int rnd,
                         input int gvt, input int ack_wait, input bit ack_in_proc,
                         input int exp_time, input int exp_tgt);
    int n;
    check({tag, "/ready_idle"}, bus.ready, 1);
    bus.event_valid = 1'b1;
    bus.event_id    = 3'(id);
    bus.event_time  = 16'(tm);
    bus.random_in   = 8'(rnd);
    bus.global_time = 14'(gvt);
    @(posedge clk);
    @(negedge clk);
    bus.event_valid = 1'b0;
    bus.ack         = ack_in_proc;
    n = 0;
    while (!bus.new_event_ready && n < 16) begin
      n++;
      @(negedge clk);
    end
    bus.ack = 1'b0;
    check({tag, "/proc_cycles"}, n, (rnd % 4) + 1);
    check({tag, "/time"}, bus.new_event_time, exp_time);
    check({tag, "/target"}, bus.new_event_target, exp_tgt);
    repeat (ack_wait) @(negedge clk);
    if (ack_wait > 0) begin
      check({tag, "/held_ready"}, bus.new_event_ready, 1);
      check({tag, "/held_time"}, bus.new_event_time, exp_time);
    end
    bus.ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ack = 1'b0;
    check({tag, "/ready_after_ack"}, bus.ready, 1);
    check({tag, "/ner_after_ack"}, bus.new_event_ready, 0);
  endtask

  // Accept an event and wait until it is offered in SEND.
  task automatic reach_send(input int id, input int tm, input int rnd);
    int n;
    bus.event_valid = 1'b1;
    bus.event_id    = 3'(id);
    bus.event_time  = 16'(tm);
    bus.random_in   = 8'(rnd);
    @(posedge clk);
    @(negedge clk);
    bus.event_valid = 1'b0;
    n = 0;
    while (!bus.new_event_ready && n < 16) begin
      n++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [2:0]  id;
    logic [15:0] tm;
    logic [7:0]  rnd;
    logic [13:0] gvt;
    logic [15:0] exp_time;
    logic [2:0]  exp_tgt;
  } vec_t;

  vec_t vecs[5];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [15:0] t_hold;
    logic [2:0]  g_hold;
    bit          stable, saw_ner;
    int          id, tm, rnd;

    // 100+0x43+INC; 2 ^ 2 = 0
    vecs[0] = '{3'd2, 16'd100,   8'h43, 14'd0,    16'(167 + TB_INC), 3'd0};
    // saturates; 7 ^ 5 = 2
    vecs[1] = '{3'd5, 16'hFFF0,  8'hFF, 14'd0,    16'hFFFF,          3'd2};
    // shortest PROC
    vecs[2] = '{3'd0, 16'd0,     8'h00, 14'd0,    16'(TB_INC),       3'd0};
    // causality violation (time < GVT) still processed; 5 ^ 7 = 2
    vecs[3] = '{3'd7, 16'd10,    8'hA1, 14'd5000, 16'(171 + TB_INC), 3'd2};
    // 0xFF00+0xFE+INC hits or exceeds the ceiling; 7 ^ 1 = 6
    vecs[4] = '{3'd1, 16'hFF00,  8'hFE, 14'd0,    16'hFFFF,          3'd6};

    bus.event_valid = 1'b0;
    bus.event_id    = '0;
    bus.event_time  = '0;
    bus.global_time = '0;
    bus.random_in   = '0;
    bus.ack         = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("reset/ready", bus.ready, 1);
    check("reset/ner", bus.new_event_ready, 0);
    check("reset/time", bus.new_event_time, 0);
    check("reset/target", bus.new_event_target, 0);

    // Directed table.
    for (int i = 0; i < 5; i++) begin
      run_txn($sformatf("vec%0d", i), int'(vecs[i].id), int'(vecs[i].tm), int'(vecs[i].rnd),
              int'(vecs[i].gvt), (i == 0) ? 3 : 0, 1'b0,
              int'(vecs[i].exp_time), int'(vecs[i].exp_tgt));
    end

    // ack during PROC is ignored.
    run_txn("ack_in_proc", 4, 1234, 8'h63, 0, 1, 1'b1, ref_time(1234, 8'h63), ref_tgt(4, 8'h63));

    // ack withheld 10 cycles, event_valid pulsed and random_in changed meanwhile.
    reach_send(3, 500, 8'h22);
    check("hold/ner", bus.new_event_ready, 1);
    check("hold/time", bus.new_event_time, ref_time(500, 8'h22));
    t_hold = bus.new_event_time;
    g_hold = bus.new_event_target;
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.event_valid = (k == 3 || k == 4);
      bus.event_id    = 3'd6;
      bus.event_time  = 16'd9;
      bus.random_in   = 8'(k * 37);
      @(negedge clk);
      if (bus.new_event_time !== t_hold || bus.new_event_target !== g_hold ||
          bus.new_event_ready !== 1'b1 || bus.ready !== 1'b0) stable = 1'b0;
    end
    bus.event_valid = 1'b0;
    check("hold/stable", stable, 1);
    bus.ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ack = 1'b0;
    check("hold/ready_after_ack", bus.ready, 1);
    repeat (3) @(negedge clk);
    check("hold/stays_idle", bus.ready, 1);

    // ack and event_valid together in SEND: only ack acts.
    reach_send(1, 50, 8'h00);
    bus.ack         = 1'b1;
    bus.event_valid = 1'b1;
    bus.random_in   = 8'h03;
    @(posedge clk);
    @(negedge clk);
    bus.ack         = 1'b0;
    bus.event_valid = 1'b0;
    check("both/ready", bus.ready, 1);
    @(negedge clk);
    check("both/not_latched", bus.ready, 1);

    // Reset mid-PROC.
    bus.event_valid = 1'b1;
    bus.event_id    = 3'd5;
    bus.event_time  = 16'd700;
    bus.random_in   = 8'h03;
    @(posedge clk);
    @(negedge clk);
    bus.event_valid = 1'b0;
    @(negedge clk);
    check("rst_proc/busy", bus.ready, 0);
    rst_n = 1'b0;
    #1;
    check("rst_proc/ready", bus.ready, 1);
    check("rst_proc/ner", bus.new_event_ready, 0);
    check("rst_proc/time", bus.new_event_time, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_ner = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.new_event_ready) saw_ner = 1'b1;
    end
    check("rst_proc/no_ner", saw_ner, 0);

    // Reset in SEND.
    reach_send(6, 40000, 8'hE1);
    check("rst_send/ner_before", bus.new_event_ready, 1);
    rst_n = 1'b0;
    #1;
    check("rst_send/ner", bus.new_event_ready, 0);
    check("rst_send/target", bus.new_event_target, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_ner = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.new_event_ready) saw_ner = 1'b1;
    end
    check("rst_send/no_ner", saw_ner, 0);
    check("rst_send/ready", bus.ready, 1);

    // Randomized transactions against the model.
    for (int i = 0; i < 24; i++) begin
      id  = int'($urandom_range(0, 7));
      tm  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(65280, 65535))
                                        : int'($urandom_range(0, 65535));
      rnd = int'($urandom_range(0, 255));
      run_txn($sformatf("rnd%0d", i), id, tm, rnd, int'($urandom_range(0, 16383)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ref_time(tm, rnd), ref_tgt(id, rnd));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
